// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared prescaled time base, edge/center counting and double-buffered duty/period
module pwm_multi #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8,
  parameter int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic [WIDTH-1:0]      i_period,
  input  logic                  i_duty_wr,
  input  logic [CHW-1:0]        i_duty_ch,
  input  logic [WIDTH-1:0]      i_duty_in,
  output logic [CHANNELS-1:0]   o_out,
  output logic                  o_period_end
);
  logic [PRESCALE_W-1:0] r_pre;
  logic [WIDTH-1:0]      r_cnt;
  logic                  r_dir;
  logic [WIDTH-1:0]      r_period;
  logic                  r_mode;
  logic                  r_period_end;
  logic                  w_tick;
  logic                  w_top;
  logic                  w_center;
  logic [WIDTH-1:0]      w_cnt_nxt;
  logic                  w_dir_nxt;
  logic                  w_bnd;

  // Center counting degenerates to edge counting when the latched period is zero
  always_comb begin
    w_tick    = i_en && (r_pre == i_prescale);
    w_top     = r_cnt >= r_period;
    w_center  = r_mode && (r_period != '0);
    w_cnt_nxt = !w_tick  ? r_cnt :
                w_center ? (r_dir ? r_cnt - 1'b1 : w_top ? r_period - 1'b1 : r_cnt + 1'b1) :
                           (w_top ? '0 : r_cnt + 1'b1);
    w_dir_nxt = !w_tick ? r_dir : (w_cnt_nxt != '0) && w_center && (r_dir || w_top);
    w_bnd     = w_tick && (w_cnt_nxt == '0);
  end

  // Shared time base; disabled state holds the counter at zero and tracks period/mode live
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre        <= '0;
      r_cnt        <= '0;
      r_dir        <= 1'b0;
      r_period     <= '0;
      r_mode       <= 1'b0;
      r_period_end <= 1'b0;
    end else if (!i_en) begin
      r_pre        <= '0;
      r_cnt        <= '0;
      r_dir        <= 1'b0;
      r_period     <= i_period;
      r_mode       <= i_mode;
      r_period_end <= 1'b0;
    end else begin
      r_pre        <= w_tick ? '0 : r_pre + 1'b1;
      r_cnt        <= w_cnt_nxt;
      r_dir        <= w_dir_nxt;
      r_period_end <= w_bnd;
      if (w_bnd) begin
        r_period <= i_period;
        r_mode   <= i_mode;
      end
    end
  end

  assign o_period_end = r_period_end;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] r_act;
    logic             r_out;
    // Writes land in pending; active takes the pre-write pending value at a boundary or while disabled
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_pend <= '0;
        r_act  <= '0;
        r_out  <= 1'b0;
      end else begin
        if (i_duty_wr && (i_duty_ch == CHW'(c))) r_pend <= i_duty_in;
        if (!i_en || w_bnd) r_act <= r_pend;
        r_out <= i_en && (r_cnt < r_act);
      end
    end
    assign o_out[c] = r_out;
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized and directed checks of pwm_multi against a period-position reference model
module tb_pwm_multi;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0, duty_wr = 1'b0;
  logic [7:0] prescale = '0, period = '0, duty_in = '0;
  logic [2:0] duty_ch = '0;
  logic [3:0] out;
  logic       pe;
  int         n_chk = 0, n_fail = 0;
  int         m_pre, m_pos, m_P, m_mode, m_pe;
  int         m_pend[4], m_act[4];
  logic [3:0] m_out;
  int         hi, np, j;
  logic [7:0] pat;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(8), .CHANNELS(4), .PRESCALE_W(8), .CHW(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_prescale(prescale),
    .i_period(period), .i_duty_wr(duty_wr), .i_duty_ch(duty_ch), .i_duty_in(duty_in),
    .o_out(out), .o_period_end(pe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mlen();
    return (m_mode != 0 && m_P > 0) ? 2 * m_P : m_P + 1;
  endfunction

  function automatic int mcnt();
    return (m_mode != 0 && m_P > 0 && m_pos > m_P) ? 2 * m_P - m_pos : m_pos;
  endfunction

  task automatic model_reset();
    m_pre = 0; m_pos = 0; m_P = 0; m_mode = 0; m_pe = 0; m_out = '0;
    for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_act[i] = 0; end
  endtask

  task automatic model_step();
    int c;
    c = mcnt();
    m_pe = 0;
    if (!en) begin
      m_out = '0; m_pre = 0; m_pos = 0; m_P = period; m_mode = mode;
      for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
    end else begin
      for (int i = 0; i < 4; i++) m_out[i] = c < m_act[i];
      if (m_pre == prescale) begin
        m_pre = 0;
        m_pos++;
        if (m_pos >= mlen()) begin
          m_pos = 0; m_pe = 1; m_P = period; m_mode = mode;
          for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
        end
      end else m_pre = (m_pre + 1) % 256;
    end
    if (duty_wr && duty_ch < 4) m_pend[duty_ch] = duty_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check("out", out, m_out);
    check("period_end", pe, m_pe);
  endtask

  task automatic write(input int ch, input int val);
    duty_wr = 1'b1; duty_ch = ch[2:0]; duty_in = val[7:0];
    cyc();
    duty_wr = 1'b0;
  endtask

  task automatic setup(input int md, input int per, input int ps, input int d0);
    en = 1'b0; mode = md[0]; period = per[7:0]; prescale = ps[7:0];
    write(0, d0);
    cyc();
    en = 1'b1;
  endtask

  task automatic count_hi(input int ch, input int n, output int h, output int p);
    h = 0; p = 0;
    repeat (n) begin cyc(); h += int'(out[ch]); p += int'(pe); end
  endtask

  task automatic wait_pe();
    int k;
    k = 0;
    do begin cyc(); k++; end while (!pe && k < 300);
    if (!pe) check("wait_pe_timeout", 0, 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    repeat (2) cyc();
    rst = 1'b0;
    check("reset_out", out, 0);
    check("reset_pe", pe, 0);
    setup(0, 9, 0, 3);
    wait_pe();
    count_hi(0, 10, hi, np);
    check("edge_high", hi, 3);
    check("edge_pe", np, 1);
    setup(1, 4, 0, 2);
    wait_pe();
    pat = '0; np = 0;
    for (int k = 0; k < 8; k++) begin cyc(); pat[k] = out[0]; np += int'(pe); end
    check("center_pattern", pat, 8'b1000_0011);
    check("center_pe", np, 1);
    setup(0, 9, 3, 5);
    wait_pe();
    count_hi(0, 40, hi, np);
    check("presc_high", hi, 20);
    check("presc_pe", np, 1);
    setup(0, 9, 0, 5);
    wait_pe();
    count_hi(0, 10, hi, np);
    check("presc0_high", hi, 5);
    check("presc0_pe", np, 1);
    en = 1'b0;
    write(1, 2);
    setup(0, 9, 0, 0);
    wait_pe();
    hi = 0;
    for (j = 1; j <= 10; j++) begin
      cyc(); hi += int'(out[1]);
      duty_wr = (j == 3); duty_ch = 3'd1; duty_in = 8'd7;
    end
    check("db_current", hi, 2);
    check("db_boundary_pe", pe, 1);
    hi = 0;
    for (j = 1; j <= 10; j++) begin
      cyc(); hi += int'(out[1]);
      duty_wr = (j == 9); duty_ch = 3'd1; duty_in = 8'd4;
    end
    check("db_next", hi, 7);
    count_hi(1, 10, hi, np);
    check("db_bwrite_old", hi, 7);
    count_hi(1, 10, hi, np);
    check("db_bwrite_new", hi, 4);
    en = 1'b0;
    write(2, 0);
    write(3, 10);
    setup(0, 9, 0, 3);
    count_hi(2, 20, hi, np);
    check("duty_zero", hi, 0);
    count_hi(3, 20, hi, np);
    check("duty_full", hi, 20);
    write(5, 99);
    wait_pe();
    count_hi(0, 20, hi, np);
    check("bad_ch_ch0", hi, 6);
    count_hi(3, 20, hi, np);
    check("bad_ch_ch3", hi, 20);
    repeat (3) cyc();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_pe", pe, 0);
    @(negedge clk);
    rst = 1'b0;
    count_hi(0, 20, hi, np);
    check("rst_duty_cleared", hi, 0);
    setup(0, 9, 0, 3);
    wait_pe();
    repeat (4) cyc();
    en = 1'b0;
    repeat (7) cyc();
    en = 1'b1;
    count_hi(0, 9, hi, np);
    check("reen_no_pe", np, 0);
    check("reen_high", hi, 3);
    cyc();
    check("reen_first_pe", pe, 1);
    repeat (3000) begin
      cyc();
      duty_wr = ($urandom_range(7) == 0);
      duty_ch = 3'($urandom_range(7));
      duty_in = 8'($urandom_range(15));
      if ($urandom_range(40) == 0) begin
        period = 8'($urandom_range(12));
        mode = 1'($urandom_range(1));
      end
      if ($urandom_range(150) == 0) begin
        en = ~en;
        if (!en) prescale = 8'($urandom_range(3));
      end
      rst = ($urandom_range(500) == 0);
    end
    rst = 1'b0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator. It succeeds the single-channel 4-bit PWM. It adds:
- configurable counter width and channel count;
- a clock prescaler;
- edge- or center-aligned counting;
- double-buffered duty/period updates applied only at period boundaries.

It sits between the control/register logic and the output pins. All channels share one time base.

## Interface
- WIDTH, 8: counter, period and duty width in bits.
- CHANNELS, 4: number of PWM outputs.
- PRESCALE_W, 8: prescaler setting width.
- CHW, $clog2(CHANNELS) (min 1): channel index width.

- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  run enable.
- MODE  in  1  0 = edge-aligned, 1 = center-aligned. Latched at boundary.
- PRESCALE  in  PRESCALE_W  tick every PRESCALE+1 cycles.
- PERIOD  in  WIDTH  terminal count. Latched at boundary.
- DUTY_WR  in  1  duty write strobe, one cycle.
- DUTY_CH  in  CHW  channel index for the write.
- DUTY_IN  in  WIDTH  duty value for the write.
- OUT  out  CHANNELS  PWM outputs, registered.
- PERIOD_END  out  1  one-cycle pulse on each boundary.

## Operation
- Reset (async, RST=1) clears all state and outputs to 0:
  - prescaler, counter, direction flag;
  - pending and active duty registers;
  - latched PERIOD/MODE;
  - OUT and PERIOD_END.
- Prescaler: pre_cnt counts 0..PRESCALE. tick=1 when pre_cnt==PRESCALE, then pre_cnt returns to 0. PRESCALE=0 gives a tick every cycle.
- Counter cnt advances only on tick.
  - Edge mode: 0,1,…,PERIOD_q, then 0. A period is PERIOD_q+1 ticks.
  - Center mode: counts up 0…PERIOD_q, then down PERIOD_q-1…1, then 0. A period is 2·PERIOD_q ticks.
  - Center mode with PERIOD_q=0 behaves as edge mode with PERIOD_q=0.
- Boundary: a tick on which cnt returns to 0. On the cycle of that tick:
  - every channel's active_duty loads from pending_duty;
  - PERIOD_q loads from PERIOD and MODE_q loads from MODE;
  - PERIOD_END=1 on the following cycle, for exactly one cycle.
- Duty write: DUTY_WR=1 stores DUTY_IN into pending_duty[DUTY_CH].
  - A write with DUTY_CH ≥ CHANNELS is ignored.
  - A write coinciding with a boundary tick lands in pending only. Active takes the pre-write pending value; the new value applies at the next boundary.
- Compare: OUT[i] <= EN & (cnt < active_duty[i]), unsigned, WIDTH bits.
  - duty=0 gives OUT constant 0.
  - Edge mode: duty ≥ PERIOD_q+1 gives OUT constant 1.
  - Center mode: duty > PERIOD_q gives OUT constant 1.
- EN=0:
  - pre_cnt, cnt and direction are held at 0; OUT=0; PERIOD_END=0;
  - active_duty, PERIOD_q and MODE_q load every cycle, so updates are immediate while disabled.
  - EN rising starts a fresh period at cnt=0 with no boundary pulse.
- EN falling mid-period forces the state to 0 on the next edge. No partial-period completion.

## Timing
- OUT has 1-cycle latency from cnt: OUT(t+1) = EN(t) & (cnt(t) < active_duty(t)).
- PERIOD_END asserts the cycle after the boundary tick, aligned with cnt=0.
- Duty write to visible OUT change is at most one full period plus 1 cycle, when EN=1.
- Async reset takes effect immediately, mid-period included.
- After RST deasserts, counting starts on the first CLK edge with EN=1.

## Test plan
- Edge duty: WIDTH=8, PRESCALE=0, PERIOD=9, duty ch0=3, EN=1. Required: OUT[0] high 3 of every 10 cycles and PERIOD_END every 10 cycles.
- Center mode: MODE=1, PERIOD=4, duty=2, PRESCALE=0. Required:
  - cnt runs 0,1,2,3,4,3,2,1;
  - OUT high 3 of 8 cycles, symmetric about cnt=0;
  - PERIOD_END every 8 cycles.
- Prescaler: PRESCALE=3, PERIOD=9, duty=5. Required: period 40 cycles with OUT high 20; PRESCALE=0 in the same run gives period 10.
- Double buffer: mid-period write of ch1 from 2 to 7, PERIOD=9. Required:
  - the current period keeps high-time 2;
  - the first period after PERIOD_END has high-time 7;
  - the same applies to a write on the exact boundary cycle, one period later.
- Extremes and invalid write, CHANNELS=4:
  - duty=0 gives OUT=0 constant;
  - duty=PERIOD+1 gives OUT=1 constant;
  - a write to DUTY_CH=5 (CHW=3 build) leaves all channels unchanged.
- Reset/enable: RST pulse mid-period gives OUT=0, PERIOD_END=0 and all duties 0 immediately. EN low for 7 cycles, then high, gives a restart from cnt=0 with no PERIOD_END on re-enable.
